// File: rtl/ysyx_220053_mem_arbiter.sv
// Two-master arbiter sharing one memory port between fetch (read-only) and load/store.
// LS has priority; a starvation counter forces a pending fetch through after STARVE_MAX LS wins.
module ysyx_220053_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  // memory
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e              state_q, state_d;
  logic                owner_ls_q, owner_ls_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [3:0]          starve_q, starve_d;

  logic idle, starve_hit, grant_ls, grant_if, resp_fire;

  // Grants are gated by rst so both readies read 0 while reset is held.
  assign idle       = (state_q == StIdle) && rst;
  assign starve_hit = if_req_valid && (starve_q == StarveMax);
  assign grant_ls   = idle && ls_req_valid && !starve_hit;
  assign grant_if   = idle && if_req_valid && !grant_ls;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    starve_d   = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ls) begin
          owner_ls_d = 1'b1;
          addr_d     = ls_addr;
          wen_d      = ls_wen;
          wdata_d    = ls_wdata;
          wmask_d    = ls_wmask;
          state_d    = StReq;
          if (!if_req_valid) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_if) begin
          owner_ls_d = 1'b0;
          addr_d     = if_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
          starve_d   = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      starve_q   <= starve_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;

  assign mem_req_valid = (state_q == StReq);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Responses outside WAIT are spurious and never reach a requester.
  assign resp_fire     = (state_q == StWait) && mem_resp_valid;
  assign if_resp_valid = resp_fire && !owner_ls_q;
  assign ls_resp_valid = resp_fire && owner_ls_q;
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Self-checking bench for ysyx_220053_mem_arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_ysyx_220053_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk, rst;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  ysyx_220053_mem_arbiter #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int total, bad;

  // Transaction-level model: one outstanding transaction, issued or not yet issued to memory.
  bit          m_busy, m_issued, m_own_ls;
  logic [63:0] m_addr, m_wdata;
  logic        m_wen;
  logic [7:0]  m_wmask;
  int          m_starve;
  int          grants[$];   // observed winners in order: 1 = LS, 0 = IF

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_own_ls = 0;
    m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0; m_starve = 0;
  endtask

  // Inputs are already applied for this cycle; check, advance the model, move to next negedge.
  task automatic tick();
    bit e_ls, e_if, resp;
    #1;
    if (!rst) begin
      chk("rst_if_ready", if_req_ready, 0);
      chk("rst_ls_ready", ls_req_ready, 0);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_if_resp", if_resp_valid, 0);
      chk("rst_ls_resp", ls_resp_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      model_reset();
    end else begin
      e_ls = !m_busy && ls_req_valid && !(if_req_valid && m_starve == STARVE_MAX);
      e_if = !m_busy && !e_ls && if_req_valid;
      resp = m_busy && m_issued && mem_resp_valid;
      chk("if_ready", if_req_ready, e_if);
      chk("ls_ready", ls_req_ready, e_ls);
      chk("mem_valid", mem_req_valid, m_busy && !m_issued);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", mem_wmask, m_wmask);
      chk("if_resp", if_resp_valid, resp && !m_own_ls);
      chk("ls_resp", ls_resp_valid, resp && m_own_ls);
      if (m_busy && m_own_ls) chk("if_rdata_idle", if_rdata, 0);
      if (m_busy && !m_own_ls) chk("ls_rdata_idle", ls_rdata, 0);
      if (resp && !m_own_ls) chk("if_rdata", if_rdata, mem_rdata);
      if (resp && m_own_ls && !m_wen) chk("ls_rdata", ls_rdata, mem_rdata);
      if (ls_req_valid && ls_req_ready) grants.push_back(1);
      else if (if_req_valid && if_req_ready) grants.push_back(0);
      if (e_ls) begin
        m_busy = 1; m_issued = 0; m_own_ls = 1;
        m_addr = ls_addr; m_wen = ls_wen; m_wdata = ls_wdata; m_wmask = ls_wmask;
        if (!if_req_valid) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end else if (e_if) begin
        m_busy = 1; m_issued = 0; m_own_ls = 0;
        m_addr = if_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
        m_starve = 0;
      end else if (m_busy && !m_issued && mem_req_ready) begin
        m_issued = 1;
      end else if (resp) begin
        m_busy = 0;
      end
    end
    @(negedge clk);
  endtask

  int exp_order[10];

  initial begin
    clk = 0; rst = 0;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    total = 0; bad = 0;
    model_reset();
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    @(negedge clk);
    tick(); tick();
    rst = 1;

    // Single fetch, memory ready immediately
    if_req_valid = 1; if_addr = 64'h8000_0000; mem_req_ready = 1;
    tick();
    if_req_valid = 0; if_addr = 64'h1234;
    #1;
    chk("fetch_mem_valid", mem_req_valid, 1);
    chk("fetch_mem_addr", mem_addr, 64'h8000_0000);
    chk("fetch_mem_wen", mem_wen, 0);
    tick();
    mem_resp_valid = 1; mem_rdata = 64'h0000_0013_0010_0093;
    #1;
    chk("fetch_resp", if_resp_valid, 1);
    chk("fetch_rdata", if_rdata, 64'h0000_0013_0010_0093);
    tick();
    mem_resp_valid = 0;
    #1 chk("fetch_pulse_end", if_resp_valid, 0);
    tick();

    // Store with memory stalling for 3 cycles
    ls_req_valid = 1; ls_addr = 64'h8000_1000; ls_wen = 1; ls_wdata = 64'hDEAD_BEEF;
    ls_wmask = 8'h0F; mem_req_ready = 0;
    tick();
    ls_req_valid = 0; ls_addr = 64'h5555; ls_wen = 0; ls_wdata = '1; ls_wmask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1;
      #1;
      chk("store_hold_valid", mem_req_valid, 1);
      chk("store_hold_addr", mem_addr, 64'h8000_1000);
      chk("store_hold_wen", mem_wen, 1);
      chk("store_hold_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("store_hold_wmask", mem_wmask, 8'h0F);
      tick();
    end
    mem_req_ready = 0; mem_resp_valid = 1;
    #1;
    chk("store_ack", ls_resp_valid, 1);
    chk("store_no_if_resp", if_resp_valid, 0);
    tick();
    mem_resp_valid = 0;
    tick();

    // Contention: both valid continuously
    grants.delete();
    ls_req_valid = 1; ls_wen = 0; if_req_valid = 1; if_addr = 64'h8000_0100;
    mem_req_ready = 1; mem_resp_valid = 1;
    repeat (30) tick();
    chk("order_count", grants.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("order_%0d", i), grants[i], exp_order[i]);

    // LS burst then LS drops: IF next, starve counter back to 0
    repeat (6) tick();
    ls_req_valid = 0;
    #1;
    chk("if_alone_grant", if_req_ready, 1);
    chk("if_alone_no_ls", ls_req_ready, 0);
    tick();
    if_req_valid = 0;
    repeat (2) tick();
    grants.delete();
    ls_req_valid = 1; if_req_valid = 1;
    repeat (15) tick();
    chk("starve_reset_ls", grants[3], 1);
    chk("starve_reset_if", grants[4], 0);
    ls_req_valid = 0; if_req_valid = 0;
    repeat (3) tick();

    // Spurious responses in IDLE and REQ
    mem_resp_valid = 1; mem_req_ready = 0;
    #1 chk("spur_idle", if_resp_valid | ls_resp_valid, 0);
    tick();
    ls_req_valid = 1; ls_addr = 64'h8000_2000;
    tick();
    ls_req_valid = 0;
    repeat (2) begin
      #1;
      chk("spur_req_resp", ls_resp_valid, 0);
      chk("spur_req_state", mem_req_valid, 1);
      tick();
    end
    mem_req_ready = 1; mem_resp_valid = 0;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1;
    #1 chk("spur_then_real", ls_resp_valid, 1);
    tick();
    mem_resp_valid = 0;

    // Reset while waiting for a response; the late response must be ignored
    if_req_valid = 1; if_addr = 64'h8000_3000; mem_req_ready = 1;
    tick();
    if_req_valid = 0;
    tick(); tick();
    rst = 0; mem_resp_valid = 1;
    #1;
    chk("rstw_mem_valid", mem_req_valid, 0);
    chk("rstw_resp", if_resp_valid | ls_resp_valid, 0);
    tick();
    rst = 1;
    #1 chk("rstw_late_resp", if_resp_valid, 0);
    tick(); tick();
    mem_resp_valid = 0;

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 199) != 0);
      if_req_valid   = ($urandom_range(0, 9) < 6);
      ls_req_valid   = ($urandom_range(0, 1) == 1);
      if_addr        = {$urandom, $urandom};
      ls_addr        = {$urandom, $urandom};
      ls_wen         = $urandom_range(0, 1) == 1;
      ls_wdata       = {$urandom, $urandom};
      ls_wmask       = 8'($urandom);
      mem_req_ready  = ($urandom_range(0, 9) < 6);
      mem_resp_valid = ($urandom_range(0, 9) < 4);
      mem_rdata      = {$urandom, $urandom};
      tick();
    end
    rst = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
